fill_arbiter: RTL and testbench



---
 rtl/fill_arbiter_if.sv | 54 +++++
 rtl/fill_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fill_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_arbiter_if.sv
// Fill arbiter bus bundle: the two fill request channels (tag comparator and
// refill path) plus the single-beat AXI-style AW/W/B write path to the
// DRAM-cache memory controller. The master modport is the arbiter's view; the
// slave modport is the view of whatever surrounds it.
interface fill_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int TAG_SIZE   = 24
);
    logic                             fill_valid_i;
    logic                             fill_ready_o;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i;

    logic                             refill_valid_i;
    logic                             refill_ready_o;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i;

    logic                             awvalid_o;
    logic                             awready_i;
    logic [ADDR_WIDTH-1:0]            awaddr_o;
    logic [ID_WIDTH-1:0]              awid_o;

    logic                             wvalid_o;
    logic                             wready_i;
    logic [TAG_SIZE+DATA_WIDTH-1:0]   wdata_o;
    logic                             wlast_o;

    logic                             bvalid_i;
    logic [ID_WIDTH-1:0]              bid_i;
    logic                             bready_o;

    modport master (
        input  fill_valid_i, fill_data_i,
        input  refill_valid_i, refill_data_i,
        input  awready_i, wready_i,
        input  bvalid_i, bid_i,
        output fill_ready_o, refill_ready_o,
        output awvalid_o, awaddr_o, awid_o,
        output wvalid_o, wdata_o, wlast_o,
        output bready_o
    );

    modport slave (
        output fill_valid_i, fill_data_i,
        output refill_valid_i, refill_data_i,
        output awready_i, wready_i,
        output bvalid_i, bid_i,
        input  fill_ready_o, refill_ready_o,
        input  awvalid_o, awaddr_o, awid_o,
        input  wvalid_o, wdata_o, wlast_o,
        input  bready_o
    );
endinterface

// File: rtl/fill_arbiter.sv
// Fill arbiter: shares the DRAM-cache write path between tag-comparator fills
// (installed dirty) and refills from main memory (installed clean). One fill is
// granted at a time, round-robin between the two sources, and issued as a
// single AW + W beat. Outstanding B responses are counted and grants stop once
// MAX_OUTSTANDING writes are awaiting their response.
module fill_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int INDEX_WIDTH     = 10,
    parameter int OFFSET_WIDTH    = 6,
    parameter int TAG_WIDTH       = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH,
    parameter int BLANK_WIDTH     = 6,
    parameter int TAG_SIZE        = 2 + TAG_WIDTH + BLANK_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fill_arbiter_if.master bus
);

    // Address split point: everything at and above it is the tag field.
    localparam int SPLIT = INDEX_WIDTH + OFFSET_WIDTH;

    // Counter wide enough to hold MAX_OUTSTANDING itself.
    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    // Source encoding doubles as the AW id and as the round-robin pointer.
    localparam logic SRC_FILL   = 1'b0;
    localparam logic SRC_REFILL = 1'b1;

    logic [0:0]                     state;
    logic                           last_grant;
    logic                           aw_pend;
    logic                           w_pend;
    logic [CNT_W-1:0]               outstanding;

    logic [ADDR_WIDTH-1:0]          awaddr_q;
    logic [ID_WIDTH-1:0]            awid_q;
    logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_q;

    logic                           can_grant;
    logic                           grant_fill;
    logic                           grant_refill;
    logic                           grant;
    logic                           grant_src;
    logic                           grant_dirty;

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] sel_req;
    logic [ADDR_WIDTH-1:0]            sel_addr;
    logic [DATA_WIDTH-1:0]            sel_data;
    logic [TAG_WIDTH-1:0]             sel_tag;

    logic                           aw_fire;
    logic                           w_fire;
    logic                           send_done;
    logic                           b_fire;

    // The response id carries nothing the arbiter needs; only the count matters.
    logic                           unused_bid;
    assign unused_bid = ^bus.bid_i;

    assign can_grant = (outstanding < CNT_MAX);

    // Round-robin pick: on contention the source not granted last time wins;
    // grants are held off during reset so no ready leaks out of a reset cycle.
    always_comb begin
        grant_fill   = 1'b0;
        grant_refill = 1'b0;
        if (rst_n && (state == S_IDLE) && can_grant) begin
            if (bus.fill_valid_i && bus.refill_valid_i) begin
                if (last_grant == SRC_FILL) begin
                    grant_refill = 1'b1;
                end else begin
                    grant_fill = 1'b1;
                end
            end else if (bus.fill_valid_i) begin
                grant_fill = 1'b1;
            end else if (bus.refill_valid_i) begin
                grant_refill = 1'b1;
            end
        end
    end

    assign grant       = grant_fill | grant_refill;
    assign grant_src   = grant_refill ? SRC_REFILL : SRC_FILL;
    assign grant_dirty = (grant_src == SRC_FILL);

    // Unpack the granted request into address, data and the tag it carries.
    always_comb begin
        sel_req  = grant_refill ? bus.refill_data_i : bus.fill_data_i;
        sel_addr = sel_req[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        sel_data = sel_req[DATA_WIDTH-1:0];
        sel_tag  = sel_addr[ADDR_WIDTH-1:SPLIT];
    end

    assign aw_fire   = aw_pend & bus.awready_i;
    assign w_fire    = w_pend & bus.wready_i;
    assign send_done = (state == S_SEND) && (!aw_pend || aw_fire) && (!w_pend || w_fire);
    assign b_fire    = bus.bvalid_i && (outstanding != '0);

    // Capture the write payload at grant time so it stays stable while the
    // memory controller back-pressures AW or W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            awaddr_q <= '0;
            awid_q   <= '0;
            wdata_q  <= '0;
        end else if (grant) begin
            awaddr_q <= {{TAG_WIDTH{1'b0}}, sel_addr[SPLIT-1:0]};
            awid_q   <= ID_WIDTH'(grant_src);
            wdata_q  <= {1'b1, grant_dirty, sel_tag, {BLANK_WIDTH{1'b0}}, sel_data};
        end
    end

    // Grant/send sequencing: AW and W complete independently, and the fill is
    // finished in the cycle the later of the two handshakes happens.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            last_grant <= SRC_FILL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state      <= S_SEND;
                        aw_pend    <= 1'b1;
                        w_pend     <= 1'b1;
                        last_grant <= grant_src;
                    end
                end
                S_SEND: begin
                    if (aw_fire) begin
                        aw_pend <= 1'b0;
                    end
                    if (w_fire) begin
                        w_pend <= 1'b0;
                    end
                    if (send_done) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    aw_pend <= 1'b0;
                    w_pend  <= 1'b0;
                end
            endcase
        end
    end

    // Writes awaiting a B response; a completion and a response in the same
    // cycle cancel out. Grants stop at the limit, so this cannot overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (send_done && !b_fire) begin
            outstanding <= outstanding + CNT_ONE;
        end else if (!send_done && b_fire) begin
            outstanding <= outstanding - CNT_ONE;
        end
    end

    assign bus.fill_ready_o   = grant_fill;
    assign bus.refill_ready_o = grant_refill;
    assign bus.awvalid_o      = aw_pend;
    assign bus.awaddr_o       = awaddr_q;
    assign bus.awid_o         = awid_q;
    assign bus.wvalid_o       = w_pend;
    assign bus.wdata_o        = wdata_q;
    assign bus.wlast_o        = w_pend;
    assign bus.bready_o       = (outstanding != '0);

endmodule

// File: tb/tb_fill_arbiter.sv
// Testbench for fill_arbiter: scenario tasks run in sequence, each checking
// its own timing, while a scoreboard process records the expected AW/W payload
// whenever a source is granted and compares it when the DUT issues the write.
module tb_fill_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ID_W   = 4;
    localparam int TAG_SZ = 24;
    localparam int WD_W   = TAG_SZ + DATA_W;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] awaddr;
        logic [WD_W-1:0]   wdata;
    } exp_t;

    logic clk;
    logic rst_n;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    exp_t sb_q[$];
    logic aw_got;
    logic w_got;

    fill_arbiter_if #(
        .ADDR_WIDTH (ADDR_W),
        .DATA_WIDTH (DATA_W),
        .ID_WIDTH   (ID_W),
        .TAG_SIZE   (TAG_SZ)
    ) bus ();

    fill_arbiter #(
        .ADDR_WIDTH      (ADDR_W),
        .DATA_WIDTH      (DATA_W),
        .ID_WIDTH        (ID_W),
        .INDEX_WIDTH     (10),
        .OFFSET_WIDTH    (6),
        .BLANK_WIDTH     (6),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: tag field is addr[31:16], index+offset is addr[15:0].
    function automatic logic [ADDR_W-1:0] exp_awaddr(input logic [ADDR_W-1:0] addr);
        return {16'h0000, addr[15:0]};
    endfunction

    function automatic logic [WD_W-1:0] exp_wdata(input logic [ADDR_W-1:0] addr,
                                                  input logic [DATA_W-1:0] data,
                                                  input logic dirty);
        return {1'b1, dirty, addr[31:16], 6'b000000, data};
    endfunction

    // Scoreboard: push on grant, compare AW and W against the oldest entry.
    initial begin
        aw_got = 1'b0;
        w_got  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_q.delete();
                aw_got = 1'b0;
                w_got  = 1'b0;
            end else begin
                if (bus.fill_ready_o)
                    sb_q.push_back('{4'd0, exp_awaddr(bus.fill_data_i[95:64]),
                                     exp_wdata(bus.fill_data_i[95:64], bus.fill_data_i[63:0], 1'b1)});
                if (bus.refill_ready_o)
                    sb_q.push_back('{4'd1, exp_awaddr(bus.refill_data_i[95:64]),
                                     exp_wdata(bus.refill_data_i[95:64], bus.refill_data_i[63:0], 1'b0)});
                if (bus.awvalid_o && bus.awready_i) begin
                    chk_cnt++;
                    if (sb_q.size() == 0)
                        $display("[TB] FAIL sb_aw_unexpected: got awaddr %h, want no write", bus.awaddr_o);
                    else if (bus.awaddr_o !== sb_q[0].awaddr || bus.awid_o !== sb_q[0].id)
                        $display("[TB] FAIL sb_aw: got addr %h id %0d, want addr %h id %0d",
                                 bus.awaddr_o, bus.awid_o, sb_q[0].awaddr, sb_q[0].id);
                    else
                        pass_cnt++;
                    aw_got = 1'b1;
                end
                if (bus.wvalid_o && bus.wready_i) begin
                    chk_cnt++;
                    if (sb_q.size() == 0)
                        $display("[TB] FAIL sb_w_unexpected: got wdata %h, want no write", bus.wdata_o);
                    else if (bus.wdata_o !== sb_q[0].wdata || bus.wlast_o !== 1'b1)
                        $display("[TB] FAIL sb_w: got wdata %h wlast %b, want %h wlast 1",
                                 bus.wdata_o, bus.wlast_o, sb_q[0].wdata);
                    else
                        pass_cnt++;
                    w_got = 1'b1;
                end
                if (aw_got && w_got) begin
                    if (sb_q.size() != 0) void'(sb_q.pop_front());
                    aw_got = 1'b0;
                    w_got  = 1'b0;
                end
            end
        end
    end

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fill_valid_i   = 1'b0;
        bus.fill_data_i    = '0;
        bus.refill_valid_i = 1'b0;
        bus.refill_data_i  = '0;
        bus.awready_i      = 1'b0;
        bus.wready_i       = 1'b0;
        bus.bvalid_i       = 1'b0;
        bus.bid_i          = '0;
    endtask

    task automatic new_fill_data();
        bus.fill_data_i = {$urandom, $urandom, $urandom};
    endtask

    task automatic new_refill_data();
        bus.refill_data_i = {$urandom, $urandom, $urandom};
    endtask

    // Hold bvalid until bready drops and check how many responses were taken.
    task automatic drain_b(input int expected, input string name);
        int n = 0;
        bus.bvalid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (!bus.bready_o) break;
            n++;
            tick();
        end
        bus.bvalid_i = 1'b0;
        chk_cnt++;
        if (n !== expected || bus.bready_o !== 1'b0)
            $display("[TB] FAIL %s_b_count: got %0d responses (bready %b), want %0d (bready 0)",
                     name, n, bus.bready_o, expected);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.fill_valid_i   = 1'b1;
        bus.refill_valid_i = 1'b1;
        tick();
        tick();
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b0) $display("[TB] FAIL reset_fill_ready: got %b want 0", bus.fill_ready_o); else pass_cnt++;
        chk_cnt++; if (bus.refill_ready_o !== 1'b0) $display("[TB] FAIL reset_refill_ready: got %b want 0", bus.refill_ready_o); else pass_cnt++;
        chk_cnt++; if (bus.awvalid_o !== 1'b0) $display("[TB] FAIL reset_awvalid: got %b want 0", bus.awvalid_o); else pass_cnt++;
        chk_cnt++; if (bus.wvalid_o !== 1'b0 || bus.wlast_o !== 1'b0) $display("[TB] FAIL reset_wvalid: got %b/%b want 0/0", bus.wvalid_o, bus.wlast_o); else pass_cnt++;
        chk_cnt++; if (bus.bready_o !== 1'b0) $display("[TB] FAIL reset_bready: got %b want 0", bus.bready_o); else pass_cnt++;
        chk_cnt++; if (bus.awaddr_o !== '0 || bus.awid_o !== '0) $display("[TB] FAIL reset_aw_payload: got %h/%h want 0/0", bus.awaddr_o, bus.awid_o); else pass_cnt++;
        chk_cnt++; if (bus.wdata_o !== '0) $display("[TB] FAIL reset_wdata: got %h want 0", bus.wdata_o); else pass_cnt++;
        bus.fill_valid_i   = 1'b0;
        bus.refill_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_fill();
        bus.awready_i   = 1'b1;
        bus.wready_i    = 1'b1;
        bus.fill_data_i = {32'h1234_5640, 64'hA5A5_A5A5_A5A5_A5A5};
        bus.fill_valid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b1 || bus.refill_ready_o !== 1'b0) $display("[TB] FAIL single_ready: got %b/%b want 1/0", bus.fill_ready_o, bus.refill_ready_o); else pass_cnt++;
        tick();
        bus.fill_valid_i = 1'b0;
        #1;
        chk_cnt++; if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b1 || bus.wlast_o !== 1'b1) $display("[TB] FAIL single_valid: got aw %b w %b last %b want 1 1 1", bus.awvalid_o, bus.wvalid_o, bus.wlast_o); else pass_cnt++;
        chk_cnt++; if (bus.awaddr_o !== 32'h0000_5640 || bus.awid_o !== 4'd0) $display("[TB] FAIL single_aw: got %h id %0d want 00005640 id 0", bus.awaddr_o, bus.awid_o); else pass_cnt++;
        chk_cnt++; if (bus.wdata_o !== {1'b1, 1'b1, 16'h1234, 6'b0, 64'hA5A5_A5A5_A5A5_A5A5}) $display("[TB] FAIL single_wdata: got %h want %h", bus.wdata_o, {1'b1, 1'b1, 16'h1234, 6'b0, 64'hA5A5_A5A5_A5A5_A5A5}); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.awvalid_o !== 1'b0 || bus.bready_o !== 1'b1) $display("[TB] FAIL single_done: got awvalid %b bready %b want 0 1", bus.awvalid_o, bus.bready_o); else pass_cnt++;
        drain_b(1, "single");
    endtask

    task automatic test_round_robin();
        int order[$];
        int when[$];
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        bus.bvalid_i  = 1'b1;
        new_fill_data();
        new_refill_data();
        bus.fill_valid_i   = 1'b1;
        bus.refill_valid_i = 1'b1;
        for (int i = 0; i < 40 && order.size() < 6; i++) begin
            #1;
            if (bus.refill_ready_o) begin order.push_back(1); when.push_back(i); end
            else if (bus.fill_ready_o) begin order.push_back(0); when.push_back(i); end
            tick();
            new_fill_data();
            new_refill_data();
        end
        bus.fill_valid_i   = 1'b0;
        bus.refill_valid_i = 1'b0;
        chk_cnt++; if (order.size() !== 6) $display("[TB] FAIL rr_grant_count: got %0d want 6", order.size()); else pass_cnt++;
        for (int k = 0; k < order.size(); k++) begin
            chk_cnt++;
            if (order[k] !== ((k % 2 == 0) ? 1 : 0)) $display("[TB] FAIL rr_order_%0d: got src %0d want %0d", k, order[k], (k % 2 == 0) ? 1 : 0);
            else pass_cnt++;
        end
        for (int k = 1; k < when.size(); k++) begin
            chk_cnt++;
            if (when[k] - when[k-1] !== 2) $display("[TB] FAIL rr_gap_%0d: got %0d cycles want 2", k, when[k] - when[k-1]);
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) tick();
        bus.bvalid_i = 1'b0;
        #1;
        chk_cnt++; if (bus.bready_o !== 1'b0) $display("[TB] FAIL rr_drained: got bready %b want 0", bus.bready_o); else pass_cnt++;
    endtask

    task automatic test_aw_stall();
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b1;
        bus.fill_data_i  = {32'hCAFE_1234, 64'h0123_4567_89AB_CDEF};
        bus.fill_valid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b1) $display("[TB] FAIL stall_accept: got %b want 1", bus.fill_ready_o); else pass_cnt++;
        tick();
        bus.fill_valid_i = 1'b0;
        #1;
        chk_cnt++; if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b1) $display("[TB] FAIL stall_n1: got aw %b w %b want 1 1", bus.awvalid_o, bus.wvalid_o); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.wvalid_o !== 1'b0 || bus.awvalid_o !== 1'b1 || bus.awaddr_o !== 32'h0000_1234) $display("[TB] FAIL stall_n2: got w %b aw %b addr %h want 0 1 00001234", bus.wvalid_o, bus.awvalid_o, bus.awaddr_o); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.awvalid_o !== 1'b1 || bus.awaddr_o !== 32'h0000_1234 || bus.bready_o !== 1'b0) $display("[TB] FAIL stall_n3: got aw %b addr %h bready %b want 1 00001234 0", bus.awvalid_o, bus.awaddr_o, bus.bready_o); else pass_cnt++;
        tick();
        bus.awready_i = 1'b1;
        #1;
        chk_cnt++; if (bus.awvalid_o !== 1'b1 || bus.awaddr_o !== 32'h0000_1234) $display("[TB] FAIL stall_n4: got aw %b addr %h want 1 00001234", bus.awvalid_o, bus.awaddr_o); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0 || bus.bready_o !== 1'b1) $display("[TB] FAIL stall_n5: got aw %b w %b bready %b want 0 0 1", bus.awvalid_o, bus.wvalid_o, bus.bready_o); else pass_cnt++;
        drain_b(1, "stall");
    endtask

    task automatic test_throttle();
        int accepts = 0;
        logic took;
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        bus.bvalid_i  = 1'b0;
        new_fill_data();
        bus.fill_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            took = bus.fill_ready_o;
            if (took) accepts++;
            tick();
            if (took) new_fill_data();
        end
        chk_cnt++; if (accepts !== 4) $display("[TB] FAIL throttle_accepts: got %0d want 4", accepts); else pass_cnt++;
        bus.bvalid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b0 || bus.bready_o !== 1'b1) $display("[TB] FAIL throttle_full: got ready %b bready %b want 0 1", bus.fill_ready_o, bus.bready_o); else pass_cnt++;
        tick();
        bus.bvalid_i = 1'b0;
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b1) $display("[TB] FAIL throttle_reopen: got %b want 1", bus.fill_ready_o); else pass_cnt++;
        tick();
        bus.fill_valid_i = 1'b0;
        drain_b(4, "throttle");
    endtask

    task automatic test_same_cycle();
        int accepts = 0;
        logic took;
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        bus.bvalid_i  = 1'b0;
        new_fill_data();
        bus.fill_valid_i = 1'b1;
        for (int i = 0; i < 10 && accepts < 2; i++) begin
            #1;
            took = bus.fill_ready_o;
            if (took) accepts++;
            tick();
            if (took) new_fill_data();
        end
        bus.fill_valid_i = 1'b0;
        tick();
        tick();
        bus.fill_valid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b1 || bus.bready_o !== 1'b1) $display("[TB] FAIL same_accept: got ready %b bready %b want 1 1", bus.fill_ready_o, bus.bready_o); else pass_cnt++;
        tick();
        bus.fill_valid_i = 1'b0;
        bus.bvalid_i     = 1'b1;
        #1;
        chk_cnt++; if (bus.awvalid_o !== 1'b1 || bus.wvalid_o !== 1'b1) $display("[TB] FAIL same_complete: got aw %b w %b want 1 1", bus.awvalid_o, bus.wvalid_o); else pass_cnt++;
        tick();
        bus.bvalid_i = 1'b0;
        drain_b(2, "same");
        bus.bvalid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.bready_o !== 1'b0) $display("[TB] FAIL empty_bready: got %b want 0", bus.bready_o); else pass_cnt++;
        tick();
        bus.bvalid_i = 1'b0;
        new_fill_data();
        bus.fill_valid_i = 1'b1;
        tick();
        bus.fill_valid_i = 1'b0;
        tick();
        tick();
        drain_b(1, "empty");
    endtask

    task automatic test_reset_mid_send();
        bus.awready_i = 1'b0;
        bus.wready_i  = 1'b0;
        new_fill_data();
        bus.fill_valid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.fill_ready_o !== 1'b1) $display("[TB] FAIL midrst_accept: got %b want 1", bus.fill_ready_o); else pass_cnt++;
        tick();
        bus.fill_valid_i = 1'b0;
        #1;
        chk_cnt++; if (bus.awvalid_o !== 1'b1) $display("[TB] FAIL midrst_sending: got %b want 1", bus.awvalid_o); else pass_cnt++;
        rst_n = 1'b0;
        tick();
        chk_cnt++; if (bus.awvalid_o !== 1'b0 || bus.wvalid_o !== 1'b0 || bus.bready_o !== 1'b0) $display("[TB] FAIL midrst_valids: got aw %b w %b bready %b want 0 0 0", bus.awvalid_o, bus.wvalid_o, bus.bready_o); else pass_cnt++;
        chk_cnt++; if (bus.awaddr_o !== '0 || bus.awid_o !== '0 || bus.wdata_o !== '0) $display("[TB] FAIL midrst_payload: got %h/%h/%h want 0/0/0", bus.awaddr_o, bus.awid_o, bus.wdata_o); else pass_cnt++;
        rst_n = 1'b1;
        bus.awready_i = 1'b1;
        bus.wready_i  = 1'b1;
        new_fill_data();
        new_refill_data();
        bus.fill_valid_i   = 1'b1;
        bus.refill_valid_i = 1'b1;
        #1;
        chk_cnt++; if (bus.refill_ready_o !== 1'b1 || bus.fill_ready_o !== 1'b0) $display("[TB] FAIL midrst_first_grant: got refill %b fill %b want 1 0", bus.refill_ready_o, bus.fill_ready_o); else pass_cnt++;
        tick();
        bus.fill_valid_i   = 1'b0;
        bus.refill_valid_i = 1'b0;
        tick();
        tick();
        drain_b(1, "midrst");
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_fill();
        test_round_robin();
        test_aw_stall();
        test_throttle();
        test_same_cycle();
        test_reset_mid_send();
        tick();
        chk_cnt++;
        if (sb_q.size() !== 0) $display("[TB] FAIL sb_leftover: got %0d pending writes want 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
